ps2_ascii_rx: RTL and testbench

Receives PS/2 keyboard frames, decodes scan-code set 2 make/break sequences and emits one ASCII character per key press on `ascii_code` with a single-cycle `ready` strobe. It sits directly upstream of `user_input` in the CryptoATM datapath and drives that block's `ascii_code` and `ready` inputs. `user_input` uses the characters for account, password, amount, currency and destination entry.

---
 rtl/atm_kbd_pkg.sv | 83 ++++++++
 rtl/ps2_frame_rx.sv | 110 +++++++++++
 rtl/ps2_ascii_rx.sv | 108 ++++++++++
 tb/tb_ps2_ascii_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/atm_kbd_pkg.sv
// Shared keyboard definitions: scan-code set 2 constants, ASCII constants,
// receiver state encoding and the scan-code to ASCII lookup.
// Ports: none (package only).
package atm_kbd_pkg;

  // Scan-code set 2 constants
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  // ASCII constants for the non-printing keys
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] chr;
  } kbd_char_t;

  // Non-extended make code to ASCII. Letters are always uppercase; shift
  // only changes the digit row.
  function automatic kbd_char_t kbd_lookup(input logic [7:0] code, input logic shifted);
    kbd_char_t r;
    r.vld = 1'b1;
    r.chr = 8'h00;
    case (code)
      8'h45: r.chr = shifted ? 8'h29 : 8'h30;
      8'h16: r.chr = shifted ? 8'h21 : 8'h31;
      8'h1E: r.chr = shifted ? 8'h40 : 8'h32;
      8'h26: r.chr = shifted ? 8'h23 : 8'h33;
      8'h25: r.chr = shifted ? 8'h24 : 8'h34;
      8'h2E: r.chr = shifted ? 8'h25 : 8'h35;
      8'h36: r.chr = shifted ? 8'h5E : 8'h36;
      8'h3D: r.chr = shifted ? 8'h26 : 8'h37;
      8'h3E: r.chr = shifted ? 8'h2A : 8'h38;
      8'h46: r.chr = shifted ? 8'h28 : 8'h39;
      8'h1C: r.chr = 8'h41;
      8'h32: r.chr = 8'h42;
      8'h21: r.chr = 8'h43;
      8'h23: r.chr = 8'h44;
      8'h24: r.chr = 8'h45;
      8'h2B: r.chr = 8'h46;
      8'h34: r.chr = 8'h47;
      8'h33: r.chr = 8'h48;
      8'h43: r.chr = 8'h49;
      8'h3B: r.chr = 8'h4A;
      8'h42: r.chr = 8'h4B;
      8'h4B: r.chr = 8'h4C;
      8'h3A: r.chr = 8'h4D;
      8'h31: r.chr = 8'h4E;
      8'h44: r.chr = 8'h4F;
      8'h4D: r.chr = 8'h50;
      8'h15: r.chr = 8'h51;
      8'h2D: r.chr = 8'h52;
      8'h1B: r.chr = 8'h53;
      8'h2C: r.chr = 8'h54;
      8'h3C: r.chr = 8'h55;
      8'h2A: r.chr = 8'h56;
      8'h1D: r.chr = 8'h57;
      8'h22: r.chr = 8'h58;
      8'h35: r.chr = 8'h59;
      8'h1A: r.chr = 8'h5A;
      SC_ENTER: r.chr = ASCII_CR;
      SC_BKSP:  r.chr = ASCII_BS;
      SC_SPACE: r.chr = ASCII_SP;
      default:  r.vld = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises ps2_clk/ps2_data, detects falling edges
// and assembles start/8 data/odd parity/stop frames.
// Latency: rx_byte_vld / frame_err pulse one cycle after the stop-bit edge is seen.
// Backpressure: none; the consumer must take rx_byte on rx_byte_vld.
// Ports: clk, rst (async high), ps2_clk, ps2_data in; rx_byte, rx_byte_vld, frame_err out.
module ps2_frame_rx
  import atm_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;
  logic       fall;
  logic       bit_in;

  rx_state_e  state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       parity_ok_q;
  logic [CW-1:0] to_cnt_q;
  logic [7:0] byte_q;
  logic       byte_vld_q;
  logic       frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = data_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_ok_q <= 1'b0;
      to_cnt_q    <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        to_cnt_q <= '0;
        case (state_q)
          RX_IDLE: begin
            // A high bit while idle is line noise, not a start bit.
            if (!bit_in) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q   <= {bit_in, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_ok_q <= ^{shift_q, bit_in};
            state_q     <= RX_STOP;
          end
          default: begin
            if (bit_in && parity_ok_q) begin
              byte_q     <= shift_q;
              byte_vld_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
        endcase
      end else if (state_q != RX_IDLE) begin
        // Abandon a stalled partial frame silently.
        if (to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_q  <= RX_IDLE;
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + CW'(1);
        end
      end
    end
  end

  assign rx_byte     = byte_q;
  assign rx_byte_vld = byte_vld_q;
  assign frame_err   = frame_err_q;

endmodule

// File: rtl/ps2_ascii_rx.sv
// PS/2 keyboard to ASCII: decodes set-2 make/break/extended sequences and
// emits one character per key press with a single-cycle ready strobe.
// Latency: ready/frame_err two cycles after the stop-bit edge is detected.
// Backpressure: none; the consumer must sample ascii_code on ready.
// Ports: clk, rst (async high), ps2_clk, ps2_data in; ascii_code[7:0], ready, frame_err out.
module ps2_ascii_rx
  import atm_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_code,
  output logic       ready,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .rx_byte_vld(rx_byte_vld),
    .frame_err  (rx_err)
  );

  logic       brk_pend_q, brk_pend_d;
  logic       ext_pend_q, ext_pend_d;
  logic       shift_l_q,  shift_l_d;
  logic       shift_r_q,  shift_r_d;
  logic [7:0] ascii_q,    ascii_d;
  logic       ready_q,    ready_d;
  logic       ferr_q,     ferr_d;
  kbd_char_t  hit;

  always_comb begin
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    shift_l_d  = shift_l_q;
    shift_r_d  = shift_r_q;
    ascii_d    = ascii_q;
    ready_d    = 1'b0;
    // Delay the error by one cycle so it lines up with where ready would be.
    ferr_d     = rx_err;
    hit        = kbd_lookup(rx_byte, shift_l_q | shift_r_q);

    if (rx_byte_vld) begin
      if (rx_byte == SC_E0) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == SC_F0) begin
        brk_pend_d = 1'b1;
      end else begin
        brk_pend_d = 1'b0;
        ext_pend_d = 1'b0;
        if (rx_byte == SC_LSHIFT) begin
          shift_l_d = ~brk_pend_q;
        end else if (rx_byte == SC_RSHIFT) begin
          shift_r_d = ~brk_pend_q;
        end else if (!brk_pend_q) begin
          if (ext_pend_q) begin
            // Keypad Enter is the only extended key that produces a character.
            if (rx_byte == SC_ENTER) begin
              ascii_d = ASCII_CR;
              ready_d = 1'b1;
            end
          end else if (hit.vld) begin
            ascii_d = hit.chr;
            ready_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      shift_l_q  <= 1'b0;
      shift_r_q  <= 1'b0;
      ascii_q    <= 8'h00;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
      ascii_q    <= ascii_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
    end
  end

  assign ascii_code = ascii_q;
  assign ready      = ready_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_ascii_rx.sv
// Testbench for ps2_ascii_rx: table-driven key sequences, hand-written reset,
// parity and timeout cases, then random key streams against a reference model.
module tb_ps2_ascii_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ascii_code;
  logic       ready;
  logic       frame_err;

  ps2_ascii_rx #(.TIMEOUT_CYCLES(200)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ascii_code(ascii_code),
    .ready     (ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int ferr_n = 0;
  int rdy_cyc = 0;
  int last_fall_cyc = 0;
  int stop_cyc = 0;

  always @(negedge clk) begin
    if (ready) begin
      got_q.push_back(ascii_code);
      rdy_cyc = cyc;
    end
    if (frame_err) ferr_n++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ bad_par);
    send_bit(1'b1);
    stop_cyc = last_fall_cyc;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_partial();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_data = 1'b1;
  endtask

  // Reference model: key tables plus the make/break/extended rules.
  logic [7:0] digit_codes [0:9] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] letter_codes [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  string digit_plain = "0123456789";
  string digit_shift = ")!@#$%^&*(";
  bit m_brk = 0, m_ext = 0, m_shl = 0, m_shr = 0;

  task automatic model_step(input logic [7:0] code);
    if (code == 8'hE0) m_ext = 1;
    else if (code == 8'hF0) m_brk = 1;
    else begin
      if (code == 8'h12) m_shl = !m_brk;
      else if (code == 8'h59) m_shr = !m_brk;
      else if (!m_brk) begin
        if (m_ext) begin
          if (code == 8'h5A) exp_q.push_back(8'h0D);
        end else begin
          for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code)
              exp_q.push_back((m_shl || m_shr) ? digit_shift[i] : digit_plain[i]);
          for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) exp_q.push_back(8'h41 + 8'(i));
          if (code == 8'h5A) exp_q.push_back(8'h0D);
          if (code == 8'h66) exp_q.push_back(8'h08);
          if (code == 8'h29) exp_q.push_back(8'h20);
        end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  typedef struct {
    int         n_in;
    logic [7:0] in_codes [0:11];
    int         n_out;
    logic [7:0] out_chr [0:4];
  } vec_t;

  vec_t vecs [0:3];

  logic [7:0] pool [0:23] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h36, 8'h46, 8'h1C, 8'h1A, 8'h2D,
                              8'h3C, 8'h12, 8'h12, 8'h59, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'hE0,
                              8'h5A, 8'h66, 8'h29, 8'h76, 8'h75, 8'h3E};

  initial begin
    logic [7:0] last_chr;
    int f0;

    vecs[0].n_in = 9;
    vecs[0].in_codes = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h3D, 8'hF0, 8'h3D, 8'h00, 8'h00, 8'h00};
    vecs[0].n_out = 3;
    vecs[0].out_chr = '{8'h31, 8'h32, 8'h37, 8'h00, 8'h00};
    vecs[1].n_in = 7;
    vecs[1].in_codes = '{8'h12, 8'h1E, 8'hF0, 8'h1E, 8'hF0, 8'h12, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].n_out = 2;
    vecs[1].out_chr = '{8'h40, 8'h32, 8'h00, 8'h00, 8'h00};
    vecs[2].n_in = 6;
    vecs[2].in_codes = '{8'h5A, 8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].n_out = 2;
    vecs[2].out_chr = '{8'h0D, 8'h0D, 8'h00, 8'h00, 8'h00};
    vecs[3].n_in = 11;
    vecs[3].in_codes = '{8'h1C, 8'h32, 8'h66, 8'h29, 8'hE0, 8'h75, 8'h76, 8'h59, 8'h1A, 8'hF0, 8'h59, 8'h00};
    vecs[3].n_out = 5;
    vecs[3].out_chr = '{8'h41, 8'h42, 8'h08, 8'h20, 8'h5A};

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_ascii", ascii_code, 8'h00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-frame, then a good 0x45
    send_partial();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_ascii", ascii_code, 8'h00);
    chk("midrst_ready", ready, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    got_q.delete();
    send_frame(8'h45, 0);
    chk("rst_frame_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("rst_frame_chr", got_q[0], 8'h30);
    chk("rst_frame_lat", rdy_cyc - stop_cyc, 4);
    last_chr = 8'h30;

    // Table-driven key sequences
    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      for (int j = 0; j < vecs[v].n_in; j++) send_frame(vecs[v].in_codes[j], 0);
      chk($sformatf("vec%0d_cnt", v), got_q.size(), vecs[v].n_out);
      for (int k = 0; k < vecs[v].n_out; k++)
        if (k < got_q.size()) chk($sformatf("vec%0d_chr%0d", v, k), got_q[k], vecs[v].out_chr[k]);
      last_chr = vecs[v].out_chr[vecs[v].n_out - 1];
    end

    // Parity error
    got_q.delete();
    f0 = ferr_n;
    send_frame(8'h45, 1);
    chk("par_ferr", ferr_n - f0, 1);
    chk("par_noready", got_q.size(), 0);
    chk("par_ascii_held", ascii_code, last_chr);

    // Timeout on a stalled partial frame
    got_q.delete();
    f0 = ferr_n;
    send_partial();
    repeat (300) @(negedge clk);
    chk("to_nopulse", got_q.size(), 0);
    send_frame(8'h1C, 0);
    chk("to_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("to_chr", got_q[0], 8'h41);
    chk("to_noerr", ferr_n - f0, 0);

    // Random key streams against the model
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    f0 = ferr_n;
    for (int r = 0; r < 50; r++) begin
      logic [7:0] c;
      c = pool[$urandom_range(0, 23)];
      model_step(c);
      send_frame(c, 0);
    end
    chk("rnd_cnt", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < got_q.size()) chk($sformatf("rnd_chr%0d", k), got_q[k], exp_q[k]);
    chk("rnd_noerr", ferr_n - f0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
